// File: rtl/truth_table_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_pkg
//
// Purpose : shared types and constants for the truth-table sweeper.
//           - state_e       : sweeper FSM states
//           - N_COMBOS      : number of input combinations of a 4-input function
//           - IDX_W         : width of the combination index
//           - CNT_W         : width of a bit count over a full table (0..16)
//           - SETTLE_W      : width of the settle counter (0..15 extra cycles)
//           - popcount_table: number of set bits in a 16-bit table
// Ports   : none (package).
// Config  : none.
// -----------------------------------------------------------------------------
package truth_table_pkg;

  localparam int N_COMBOS = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 5;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Number of ones in a complete truth table; 5 bits so that 16 fits.
  function automatic logic [CNT_W-1:0] popcount_table(input logic [N_COMBOS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_COMBOS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage : truth_table_pkg

// File: rtl/truth_table_sweeper_index_counter.sv
// -----------------------------------------------------------------------------
// tt_index_counter
//
// Purpose : combination index and settle counter for the truth-table sweeper.
//           The settle counter runs up from 0 and saturates at SETTLE_CYCLES;
//           'settled' is high once it got there. 'advance' steps to the next
//           combination and restarts settling; 'clear' returns both counters
//           to 0 (start of a sweep, and the 15->0 wrap at the end of a sweep).
//
// Parameters:
//   SETTLE_CYCLES : extra hold cycles per combination (0..15)
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst_n   in   1      synchronous active-low reset
//   clear   in   1      zero index and settle counter (has priority)
//   advance in   1      index+1, settle counter back to 0
//   idx     out  IDX_W  current combination index
//   settled out  1      settle counter has reached SETTLE_CYCLES
//   last    out  1      index is at the final combination (15)
// Config  : none.
// -----------------------------------------------------------------------------
module tt_index_counter
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic             settled,
  output logic             last
);

  localparam logic [SETTLE_W-1:0] SETTLE_LIM = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_COMBOS - 1);

  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  assign settled = (settle_q == SETTLE_LIM);
  assign last    = (idx_q == IDX_LAST);
  assign idx     = idx_q;

  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    if (clear) begin
      idx_d    = '0;
      settle_d = '0;
    end else if (advance) begin
      idx_d    = idx_q + 1'b1;
      settle_d = '0;
    end else if (!settled) begin
      // Saturating: once settled the count stays put until the next
      // advance/clear, so it never wraps while the FSM sits in SAMPLE.
      settle_d = settle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      settle_q <= '0;
    end else begin
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

endmodule : tt_index_counter

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose : drives all 16 combinations of {a,b,c,d} into an external 4-input
//           combinational block, samples its response x for each and builds
//           the 16-bit truth table (bit i = x for combination i). Combination
//           i is presented as {a,b,c,d} = ~i, so the table columns match
//           a=00FF, b=0F0F, c=3333, d=5555.
//           Each combination is held SETTLE_CYCLES+1 cycles in HOLD, then x is
//           captured during one SAMPLE cycle. FINISH lasts one cycle and
//           drives the done pulse.
//
// Parameters:
//   SETTLE_CYCLES : extra hold cycles per combination before sampling (0..15)
//   EXPECTED      : reference table, only used when SWEEP_CHECK_EN is defined
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   start        in   1   begin a sweep (only looked at in IDLE)
//   x            in   1   response of the logic under test
//   a,b,c,d      out  1   stimulus to the logic under test
//   busy         out  1   high in HOLD/SAMPLE/FINISH
//   done         out  1   one-cycle pulse, table_out complete
//   table_out    out  16  captured truth table
//   mismatch     out  1   table differs from EXPECTED
//   mismatch_cnt out  5   number of differing table bits
//
// Config  : define SWEEP_CHECK_EN to build the compare against EXPECTED;
//           without it mismatch and mismatch_cnt are constant 0.
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int                    SETTLE_CYCLES = 0,
  parameter logic [N_COMBOS-1:0]   EXPECTED      = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                x,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                busy,
  output logic                done,
  output logic [N_COMBOS-1:0] table_out,
  output logic                mismatch,
  output logic [CNT_W-1:0]    mismatch_cnt
);

  state_e              state_q, state_d;
  logic [N_COMBOS-1:0] table_q, table_d;
  logic [3:0]          stim;

  logic [IDX_W-1:0]    idx;
  logic                settled;
  logic                last;
  logic                cnt_clear;
  logic                cnt_advance;

  tt_index_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_index_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .idx     (idx),
    .settled (settled),
    .last    (last)
  );

  // ---------------------------------------------------------------------------
  // Next state, table capture and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    stim        = 4'b0000;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = HOLD;
          cnt_clear = 1'b1;
          table_d   = '0;
        end
      end

      HOLD: begin
        stim = ~idx;
        if (settled) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        stim         = ~idx;
        table_d[idx] = x;
        if (last) begin
          // Index stays at 15 here; the wrap to 0 happens in FINISH.
          state_d = FINISH;
        end else begin
          cnt_advance = 1'b1;
          state_d     = HOLD;
        end
      end

      FINISH: begin
        done      = 1'b1;
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
    end
  end

  assign {a, b, c, d} = stim;
  assign table_out    = table_q;

  // ---------------------------------------------------------------------------
  // Optional compare against the reference table
  // ---------------------------------------------------------------------------
`ifdef SWEEP_CHECK_EN
  logic [CNT_W-1:0] live_cnt;
  logic [CNT_W-1:0] held_cnt_q, held_cnt_d;

  // The table is complete throughout FINISH, so the count is presented
  // combinationally alongside done and latched for the following IDLE.
  assign live_cnt = popcount_table(table_q ^ EXPECTED);

  always_comb begin
    held_cnt_d = held_cnt_q;
    if (state_q == IDLE && start) begin
      held_cnt_d = '0;
    end else if (state_q == FINISH) begin
      held_cnt_d = live_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_cnt_q <= '0;
    end else begin
      held_cnt_q <= held_cnt_d;
    end
  end

  assign mismatch_cnt = (state_q == FINISH) ? live_cnt : held_cnt_q;
  assign mismatch     = (mismatch_cnt != '0);
`else
  assign mismatch_cnt = '0;
  assign mismatch     = 1'b0;
`endif

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweepers share one clock: unit 0 with SETTLE_CYCLES=0, unit 1 with
// SETTLE_CYCLES=2. Each unit's x is produced by a 16-entry lookup indexed by
// {a,b,c,d}, so any 4-input function can be plugged in. The expected table
// is derived from the column patterns a=00FF, b=0F0F, c=3333, d=5555.
// Latency is counted as rising edges from the start-accepting edge up to the
// first edge that captures done high.
// Build with +define+SWEEP_CHECK_EN to check the compare outputs against
// EXPECTED=16'h111F.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  localparam logic [15:0] PAT_A   = 16'h00FF;
  localparam logic [15:0] PAT_B   = 16'h0F0F;
  localparam logic [15:0] PAT_C   = 16'h3333;
  localparam logic [15:0] PAT_D   = 16'h5555;
  localparam logic [15:0] EXP_REF = 16'h111F;

  logic        clk = 1'b0;
  logic        rst_n_v  [2];
  logic        start_v  [2];
  logic        x_v      [2];
  logic        a_v      [2];
  logic        b_v      [2];
  logic        c_v      [2];
  logic        d_v      [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic [15:0] table_v  [2];
  logic        mm_v     [2];
  logic [4:0]  mcnt_v   [2];
  logic [15:0] lut_v    [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.SETTLE_CYCLES(0), .EXPECTED(EXP_REF)) dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .x(x_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .table_out(table_v[0]),
    .mismatch(mm_v[0]), .mismatch_cnt(mcnt_v[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(EXP_REF)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .x(x_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .table_out(table_v[1]),
    .mismatch(mm_v[1]), .mismatch_cnt(mcnt_v[1])
  );

  // Logic under test: a lookup table addressed by {a,b,c,d}.
  always_comb x_v[0] = lut_v[0][{a_v[0], b_v[0], c_v[0], d_v[0]}];
  always_comb x_v[1] = lut_v[1][{a_v[1], b_v[1], c_v[1], d_v[1]}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lookup for x = (a&b)|(c&d), addressed by {a,b,c,d}.
  function automatic logic [15:0] lut_ab_or_cd();
    logic [15:0] l;
    for (int k = 0; k < 16; k++) begin
      l[k] = (k[3] & k[2]) | (k[1] & k[0]);
    end
    return l;
  endfunction

  // Lookup for x = a.
  function automatic logic [15:0] lut_a();
    logic [15:0] l;
    for (int k = 0; k < 16; k++) l[k] = k[3];
    return l;
  endfunction

  // Table bit i = f(a,b,c,d) with a..d taken from column i of the patterns.
  function automatic logic [15:0] expected_table(input logic [15:0] lut);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) begin
      t[i] = lut[{PAT_A[i], PAT_B[i], PAT_C[i], PAT_D[i]}];
    end
    return t;
  endfunction

  function automatic logic [4:0] expected_cnt(input logic [15:0] t);
`ifdef SWEEP_CHECK_EN
    return 5'($countones(t ^ EXP_REF));
`else
    return 5'(t & 16'h0000);
`endif
  endfunction

  // One complete sweep on unit u. Optionally toggles start randomly while
  // busy; any restart would break the stimulus sequence check.
  task automatic run_sweep(input int u, input logic [15:0] lut, input bit pulse_busy, input string tag);
    int          per;
    int          total;
    int          bad;
    int          done_at;
    int          k;
    logic [15:0] exp_t;
    logic [4:0]  exp_c;
    logic [3:0]  exp_abcd;
    logic [15:0] tbl_at_done;
    logic [4:0]  cnt_at_done;
    logic        mm_at_done;
    logic        done_next;
    per      = (u == 0) ? 2 : 4;
    total    = 16 * per;
    exp_t    = expected_table(lut);
    exp_c    = expected_cnt(exp_t);
    bad      = 0;
    done_at  = -1;
    done_next = 1'bx;
    tbl_at_done = 'x;
    cnt_at_done = 'x;
    mm_at_done  = 1'bx;
    lut_v[u] = lut;
    @(negedge clk);
    start_v[u] = 1'b1;
    @(posedge clk);              // start-accepting edge
    @(negedge clk);
    start_v[u] = 1'b0;
    for (int m = 0; m < total + 4; m++) begin
      // Sampling after edge m (edge 0 = accepting edge).
      if (m < total) begin
        k = m / per;
        exp_abcd = {PAT_A[k], PAT_B[k], PAT_C[k], PAT_D[k]};
        if ({a_v[u], b_v[u], c_v[u], d_v[u]} !== exp_abcd || busy_v[u] !== 1'b1)
          bad++;
      end
      if (done_at >= 0 && m == done_at) done_next = done_v[u];
      if (done_v[u] === 1'b1 && done_at < 0) begin
        done_at     = m + 1;
        tbl_at_done = table_v[u];
        cnt_at_done = mcnt_v[u];
        mm_at_done  = mm_v[u];
      end
      start_v[u] = (pulse_busy && m < total) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    check($sformatf("%s_latency", tag), done_at, total + 1);
    check($sformatf("%s_stim_seq_errs", tag), bad, 0);
    check($sformatf("%s_table_at_done", tag), tbl_at_done, exp_t);
    check($sformatf("%s_done_one_cycle", tag), done_next, 1'b0);
    check($sformatf("%s_mcnt_at_done", tag), cnt_at_done, exp_c);
    check($sformatf("%s_mm_at_done", tag), mm_at_done, (exp_c != 0));
    check($sformatf("%s_idle_busy", tag), busy_v[u], 1'b0);
    check($sformatf("%s_idle_abcd", tag), {a_v[u], b_v[u], c_v[u], d_v[u]}, 4'b0000);
    check($sformatf("%s_table_held", tag), table_v[u], exp_t);
    check($sformatf("%s_mcnt_held", tag), mcnt_v[u], exp_c);
    $display("sweep %s unit=%0d lut=%04h table=%04h latency=%0d", tag, u, lut, table_v[u], done_at);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit          found;
    int          done_seen;
    logic [15:0] rl;

    for (int u = 0; u < 2; u++) begin
      rst_n_v[u] = 1'b0;
      start_v[u] = 1'b0;
      lut_v[u]   = 16'hFFFF;
    end
    repeat (3) @(negedge clk);

    // Reset state: start held low, x high, everything must be quiet.
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_busy_u%0d", u), busy_v[u], 1'b0);
      check($sformatf("rst_done_u%0d", u), done_v[u], 1'b0);
      check($sformatf("rst_table_u%0d", u), table_v[u], 16'h0000);
      check($sformatf("rst_abcd_u%0d", u), {a_v[u], b_v[u], c_v[u], d_v[u]}, 4'b0000);
      check($sformatf("rst_mm_u%0d", u), mm_v[u], 1'b0);
      check($sformatf("rst_mcnt_u%0d", u), mcnt_v[u], 5'd0);
      $display("reset unit=%0d busy=%0b done=%0b table=%04h", u, busy_v[u], done_v[u], table_v[u]);
    end
    rst_n_v[0] = 1'b1;
    rst_n_v[1] = 1'b1;
    @(negedge clk);

    // Directed functions with SETTLE_CYCLES=0.
    run_sweep(0, lut_ab_or_cd(), 1'b0, "ab_or_cd");
    check("ab_or_cd_literal", table_v[0], 16'h111F);
    run_sweep(0, lut_a(), 1'b0, "x_eq_a");
    check("x_eq_a_literal", table_v[0], 16'h00FF);
    run_sweep(0, 16'h0000, 1'b0, "x_zero");
    check("x_zero_literal", table_v[0], 16'h0000);
    run_sweep(0, 16'hFFFF, 1'b0, "x_one");
    check("x_one_literal", table_v[0], 16'hFFFF);

    // SETTLE_CYCLES=2 with start pulses while busy.
    run_sweep(1, lut_ab_or_cd(), 1'b1, "s2_ab_or_cd");
    for (int r = 0; r < 3; r++) begin
      rl = 16'($urandom);
      run_sweep(1, rl, 1'b1, $sformatf("s2_rand%0d", r));
      rl = 16'($urandom);
      run_sweep(0, rl, 1'b1, $sformatf("s0_rand%0d", r));
    end

    // Start held high: a new sweep begins right after FINISH and clears the table.
    lut_v[0] = 16'hFFFF;
    @(negedge clk);
    start_v[0] = 1'b1;
    found = 1'b0;
    for (int m = 0; m < 80 && !found; m++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) found = 1'b1;
    end
    check("held_start_done_seen", found, 1'b1);
    @(negedge clk);
    check("held_start_idle_busy", busy_v[0], 1'b0);
    check("held_start_idle_table", table_v[0], 16'hFFFF);
    @(negedge clk);
    check("held_start_restart_busy", busy_v[0], 1'b1);
    check("held_start_table_cleared", table_v[0], 16'h0000);
    $display("held start restart busy=%0b table=%04h", busy_v[0], table_v[0]);
    start_v[0] = 1'b0;
    rst_n_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_v[0] = 1'b1;
    @(negedge clk);

    // Reset mid-sweep at combination 7 ({a,b,c,d} = ~7).
    lut_v[0] = 16'hFFFF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int m = 0; m < 60 && !found; m++) begin
      if ({a_v[0], b_v[0], c_v[0], d_v[0]} === 4'b1000) found = 1'b1;
      else @(negedge clk);
    end
    check("midrst_reached_idx7", found, 1'b1);
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy_v[0], 1'b0);
    check("midrst_done", done_v[0], 1'b0);
    check("midrst_table", table_v[0], 16'h0000);
    check("midrst_abcd", {a_v[0], b_v[0], c_v[0], d_v[0]}, 4'b0000);
    rst_n_v[0] = 1'b1;
    done_seen = 0;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    $display("mid-sweep reset busy=%0b table=%04h done_pulses=%0d", busy_v[0], table_v[0], done_seen);
    run_sweep(0, lut_ab_or_cd(), 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_truth_table_sweeper
